// File: rtl/fifo_pkg.sv
// Gray/binary helpers shared by the read and write pointer blocks of the dual-clock FIFO.
package fifo_pkg;

  localparam int unsigned MAX_PTR_W = 32;

  typedef logic [MAX_PTR_W-1:0] ptrWord_t;

  // Callers zero-extend narrower pointers; leading zeros leave both conversions exact at any width.
  function automatic ptrWord_t bin2gray(input ptrWord_t bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic ptrWord_t gray2bin(input ptrWord_t gray);
    ptrWord_t bin;
    bin[MAX_PTR_W-1] = gray[MAX_PTR_W-1];
    for (int i = MAX_PTR_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a Gray-coded bus crossing into the local clock domain.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] metaStage_q;
  logic [WIDTH-1:0] syncStage_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      metaStage_q <= '0;
      syncStage_q <= '0;
    end else begin
      metaStage_q <= d_i;
      syncStage_q <= metaStage_q;
    end
  end

  assign q_o = syncStage_q;

endmodule

// File: rtl/rd_pntrs_and_empty.sv
// Read-domain pointer, empty flag, fill level and underflow pulse of the dual-clock FIFO.
module rd_pntrs_and_empty
  import fifo_pkg::*;
#(
  parameter int unsigned AWIDTH = 4
) (
  input  logic              rd_clk_i,
  input  logic              aclr_n_i,
  input  logic              rd_req_i,
  input  logic [AWIDTH:0]   wr_pntr_gray_i,
  output logic [AWIDTH-1:0] rd_pntr_o,
  output logic [AWIDTH:0]   rd_pntr_gray_wr_o,
  output logic              rd_empty_o,
  output logic [AWIDTH:0]   rd_usedw_o,
  output logic              rd_underflow_o
);

  localparam int unsigned PW  = AWIDTH + 1;
  localparam int unsigned PAD = MAX_PTR_W - PW;

  logic [PW-1:0] wrGraySync;
  logic [PW-1:0] wrBinSync;
  logic [PW-1:0] rdBin_q,  rdBin_d;
  logic [PW-1:0] rdGray_q, rdGray_d;
  logic [PW-1:0] usedw_q,  usedw_d;
  logic          empty_q,  empty_d;
  logic          underflow_q, underflow_d;
  logic          readAccept;
  ptrWord_t      rdGrayWide;
  ptrWord_t      wrBinWide;
  logic          unusedWideBits;

  sync_2ff #(
    .WIDTH(PW)
  ) wrPntrSync (
    .clk_i  (rd_clk_i),
    .rst_n_i(aclr_n_i),
    .d_i    (wr_pntr_gray_i),
    .q_o    (wrGraySync)
  );

  // Empty and usedw are derived from the post-read pointer so an accepted read is reflected on the same edge.
  always_comb begin
    readAccept  = rd_req_i & ~empty_q;
    rdBin_d     = rdBin_q + {{AWIDTH{1'b0}}, readAccept};
    rdGrayWide  = bin2gray({{PAD{1'b0}}, rdBin_d});
    rdGray_d    = rdGrayWide[PW-1:0];
    wrBinWide   = gray2bin({{PAD{1'b0}}, wrGraySync});
    wrBinSync   = wrBinWide[PW-1:0];
    empty_d     = (rdGray_d == wrGraySync);
    usedw_d     = wrBinSync - rdBin_d;
    underflow_d = rd_req_i & empty_q;
  end

  assign unusedWideBits = ^{rdGrayWide[MAX_PTR_W-1:PW], wrBinWide[MAX_PTR_W-1:PW]};

  always_ff @(posedge rd_clk_i or negedge aclr_n_i) begin
    if (!aclr_n_i) begin
      rdBin_q     <= '0;
      rdGray_q    <= '0;
      usedw_q     <= '0;
      empty_q     <= 1'b1;
      underflow_q <= 1'b0;
    end else begin
      rdBin_q     <= rdBin_d;
      rdGray_q    <= rdGray_d;
      usedw_q     <= usedw_d;
      empty_q     <= empty_d;
      underflow_q <= underflow_d;
    end
  end

  assign rd_pntr_o         = rdBin_q[AWIDTH-1:0];
  assign rd_pntr_gray_wr_o = rdGray_q;
  assign rd_empty_o        = empty_q;
  assign rd_usedw_o        = usedw_q;
  assign rd_underflow_o    = underflow_q;

endmodule

// File: tb/tb_rd_pntrs_and_empty.sv
// Bench for rd_pntrs_and_empty: directed read/write-pointer scenarios checked against a count-based model.
module tb_rd_pntrs_and_empty;

  localparam int AWIDTH = 4;
  localparam int PW     = AWIDTH + 1;
  localparam int MODN   = 32;
  localparam int DEPTH  = 16;

  logic              clk = 1'b0;
  logic              aclrN = 1'b0;
  logic              rdReq = 1'b0;
  logic [PW-1:0]     wrGray = '0;
  logic [AWIDTH-1:0] rdPntr;
  logic [PW-1:0]     rdGrayWr;
  logic              rdEmpty;
  logic [PW-1:0]     rdUsedw;
  logic              rdUnderflow;

  int checks   = 0;
  int failures = 0;

  // Model: reads and writes as counts modulo 32; a write becomes visible two edges after it is sampled.
  int mRead      = 0;
  int mHist1     = 0;
  int mHist2     = 0;
  int mUsedw     = 0;
  bit mEmpty     = 1'b1;
  bit mUnderflow = 1'b0;

  always #5 clk = ~clk;

  rd_pntrs_and_empty #(
    .AWIDTH(AWIDTH)
  ) dut (
    .rd_clk_i         (clk),
    .aclr_n_i         (aclrN),
    .rd_req_i         (rdReq),
    .wr_pntr_gray_i   (wrGray),
    .rd_pntr_o        (rdPntr),
    .rd_pntr_gray_wr_o(rdGrayWr),
    .rd_empty_o       (rdEmpty),
    .rd_usedw_o       (rdUsedw),
    .rd_underflow_o   (rdUnderflow)
  );

  function automatic int grayToCount(input logic [PW-1:0] g);
    logic [PW-1:0] cand;
    for (int v = 0; v < MODN; v++) begin
      cand = PW'(v);
      if ((cand ^ (cand >> 1)) == g) return v;
    end
    return 0;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s at %0t: actual=%0d required=%0d", name, $time, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic req, input logic [PW-1:0] gray, input int cycles);
    rdReq  = req;
    wrGray = gray;
    repeat (cycles) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic doReset();
    aclrN  = 1'b0;
    rdReq  = 1'b0;
    wrGray = '0;
    @(negedge clk);
    aclrN = 1'b1;
    applyStimulus(1'b0, '0, 2);
  endtask

  always @(posedge clk or negedge aclrN) begin
    if (!aclrN) begin
      mRead      = 0;
      mHist1     = 0;
      mHist2     = 0;
      mUsedw     = 0;
      mEmpty     = 1'b1;
      mUnderflow = 1'b0;
    end else begin
      int visible;
      mUnderflow = rdReq && mEmpty;
      if (rdReq && !mEmpty) mRead = (mRead + 1) % MODN;
      visible = mHist2;
      mHist2  = mHist1;
      mHist1  = grayToCount(wrGray);
      mUsedw  = (visible - mRead + MODN) % MODN;
      mEmpty  = (mUsedw == 0);
    end
  end

  always @(negedge clk) begin
    if (aclrN) begin
      checkOutput("model rd_pntr_o", 32'(rdPntr), mRead % DEPTH);
      checkOutput("model rd_pntr_gray_wr_o", 32'(rdGrayWr), mRead ^ (mRead >> 1));
      checkOutput("model rd_empty_o", 32'(rdEmpty), 32'(mEmpty));
      checkOutput("model rd_usedw_o", 32'(rdUsedw), mUsedw);
      checkOutput("model rd_underflow_o", 32'(rdUnderflow), 32'(mUnderflow));
    end
  end

  initial begin
    #12;
    checkOutput("reset held empty", 32'(rdEmpty), 1);
    checkOutput("reset held usedw", 32'(rdUsedw), 0);
    checkOutput("reset held pntr", 32'(rdPntr), 0);
    checkOutput("reset held gray", 32'(rdGrayWr), 0);
    checkOutput("reset held underflow", 32'(rdUnderflow), 0);
    @(negedge clk);
    aclrN = 1'b1;
    applyStimulus(1'b0, 5'b00000, 2);
    checkOutput("after release empty", 32'(rdEmpty), 1);
    checkOutput("after release usedw", 32'(rdUsedw), 0);

    // Write visibility: first edge latches, second synchronises, third shows the word.
    applyStimulus(1'b0, 5'b00001, 1);
    checkOutput("visibility edge1 empty", 32'(rdEmpty), 1);
    applyStimulus(1'b0, 5'b00001, 1);
    checkOutput("visibility edge2 empty", 32'(rdEmpty), 1);
    checkOutput("visibility edge2 usedw", 32'(rdUsedw), 0);
    applyStimulus(1'b0, 5'b00001, 1);
    checkOutput("visibility edge3 empty", 32'(rdEmpty), 0);
    checkOutput("visibility edge3 usedw", 32'(rdUsedw), 1);
    applyStimulus(1'b1, 5'b00001, 1);
    checkOutput("single read empty", 32'(rdEmpty), 1);
    checkOutput("single read pntr", 32'(rdPntr), 1);
    checkOutput("single read gray", 32'(rdGrayWr), 5'b00001);
    applyStimulus(1'b0, 5'b00001, 1);

    // Full drain of 16 words.
    doReset();
    applyStimulus(1'b0, 5'b11000, 3);
    checkOutput("full usedw", 32'(rdUsedw), 16);
    checkOutput("full empty", 32'(rdEmpty), 0);
    for (int i = 1; i <= 16; i++) begin
      applyStimulus(1'b1, 5'b11000, 1);
      checkOutput("drain pntr", 32'(rdPntr), i % 16);
      checkOutput("drain usedw", 32'(rdUsedw), 16 - i);
    end
    checkOutput("drained gray", 32'(rdGrayWr), 5'b11000);
    checkOutput("drained empty", 32'(rdEmpty), 1);

    // Underflow: three cycles of requests while empty, then a single-cycle pulse.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 5'b11000, 1);
      checkOutput("underflow held", 32'(rdUnderflow), 1);
      checkOutput("underflow pntr", 32'(rdPntr), 0);
    end
    applyStimulus(1'b0, 5'b11000, 1);
    checkOutput("underflow cleared", 32'(rdUnderflow), 0);
    applyStimulus(1'b1, 5'b11000, 1);
    checkOutput("underflow pulse high", 32'(rdUnderflow), 1);
    applyStimulus(1'b0, 5'b11000, 1);
    checkOutput("underflow pulse low", 32'(rdUnderflow), 0);

    // MSB wrap: bring the read pointer to 30, then the write pointer to 2.
    doReset();
    applyStimulus(1'b0, 5'b01001, 3);
    checkOutput("wrap prefill usedw", 32'(rdUsedw), 14);
    applyStimulus(1'b1, 5'b01001, 14);
    applyStimulus(1'b0, 5'b10001, 3);
    checkOutput("wrap second fill usedw", 32'(rdUsedw), 16);
    applyStimulus(1'b1, 5'b10001, 16);
    checkOutput("wrap at 30 pntr", 32'(rdPntr), 14);
    checkOutput("wrap at 30 gray", 32'(rdGrayWr), 5'b10001);
    applyStimulus(1'b0, 5'b00011, 3);
    checkOutput("wrap usedw", 32'(rdUsedw), 4);
    applyStimulus(1'b1, 5'b00011, 1);
    checkOutput("wrap read1 pntr", 32'(rdPntr), 15);
    applyStimulus(1'b1, 5'b00011, 1);
    checkOutput("wrap read2 pntr", 32'(rdPntr), 0);
    checkOutput("wrap read2 usedw", 32'(rdUsedw), 2);
    checkOutput("wrap read2 empty", 32'(rdEmpty), 0);
    applyStimulus(1'b1, 5'b00011, 2);
    checkOutput("wrap final pntr", 32'(rdPntr), 2);
    checkOutput("wrap final gray", 32'(rdGrayWr), 5'b00011);
    checkOutput("wrap final empty", 32'(rdEmpty), 1);
    applyStimulus(1'b0, 5'b00011, 1);

    // Reset between clock edges while holding five words.
    doReset();
    applyStimulus(1'b0, 5'b00111, 3);
    checkOutput("midstream usedw", 32'(rdUsedw), 5);
    #2;
    aclrN = 1'b0;
    #1;
    checkOutput("async reset empty", 32'(rdEmpty), 1);
    checkOutput("async reset usedw", 32'(rdUsedw), 0);
    checkOutput("async reset pntr", 32'(rdPntr), 0);
    checkOutput("async reset gray", 32'(rdGrayWr), 0);
    checkOutput("async reset underflow", 32'(rdUnderflow), 0);
    wrGray = '0;
    @(negedge clk);
    aclrN = 1'b1;
    applyStimulus(1'b0, 5'b00000, 3);
    checkOutput("post reset empty", 32'(rdEmpty), 1);
    checkOutput("post reset usedw", 32'(rdUsedw), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
